// File: rtl/synq_op_dispatcher.sv
// PCPI sequencer: decodes the custom R-type insn and hands operands to one of NUM_OPS 16-bit units.
// Optional watchdog enabled by defining SYNQ_DISPATCH_TIMEOUT_EN.
module synq_op_dispatcher #(
    parameter int unsigned NUM_OPS        = 5,
    parameter logic [6:0]  CUSTOM_FUNCT7  = 7'b0000001,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pico_valid,
    input  logic [31:0]            pico_insn,
    input  logic [31:0]            pico_rs1,
    input  logic [31:0]            pico_rs2,
    output logic                   pico_wr,
    output logic [31:0]            pico_rd,
    output logic                   pico_wait,
    output logic                   pico_ready,
    output logic [15:0]            op_a,
    output logic [15:0]            op_b,
    output logic [15:0]            op_c,
    output logic [15:0]            op_d,
    output logic [NUM_OPS-1:0]     op_in_stb,
    input  logic [NUM_OPS-1:0]     op_in_busy,
    input  logic [16*NUM_OPS-1:0]  op_result,
    input  logic [NUM_OPS-1:0]     op_out_stb,
    output logic [NUM_OPS-1:0]     op_out_busy,
    output logic                   timeout_flag
);

    typedef enum logic [1:0] {StIdle, StIssue, StExec, StResp} state_t;

    localparam logic [6:0] OpcodeR = 7'b0110011;

    state_t             state;
    logic [2:0]         sel;
    logic [2:0]         funct3;
    logic               claim;
    logic [NUM_OPS-1:0] req_mask;
    logic [NUM_OPS-1:0] sel_mask;
    logic [15:0]        sel_result;
    logic               in_ack;
    logic               out_ack;
    logic               timeout_hit;

    assign funct3 = pico_insn[14:12];
    assign claim  = pico_valid && (pico_insn[6:0] == OpcodeR) &&
                    (pico_insn[31:25] == CUSTOM_FUNCT7) &&
                    (32'(funct3) < NUM_OPS) && !pico_ready;

    // Unit decode for the incoming insn and for the latched selection.
    always_comb begin
        req_mask   = '0;
        sel_mask   = '0;
        sel_result = '0;
        for (int i = 0; i < int'(NUM_OPS); i++) begin
            req_mask[i] = (32'(funct3) == i);
            sel_mask[i] = (32'(sel) == i);
            if (sel_mask[i]) begin
                sel_result = op_result[16*i +: 16];
            end
        end
    end

    assign in_ack  = |(op_in_stb & op_in_busy & sel_mask);
    assign out_ack = |(op_out_stb & ~op_out_busy & sel_mask);

`ifdef SYNQ_DISPATCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in ISSUE+EXEC.
    assign timeout_hit = ((state == StIssue) || (state == StExec)) &&
                         (cnt == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == StIdle) begin
                cnt <= '0;
            end else if ((state == StIssue) || (state == StExec)) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_flag       = 1'b0;
`endif

    logic unused_insn;

    assign unused_insn = ^{pico_insn[24:15], pico_insn[11:7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            sel         <= '0;
            pico_wr     <= 1'b0;
            pico_rd     <= '0;
            pico_wait   <= 1'b0;
            pico_ready  <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_c        <= '0;
            op_d        <= '0;
            op_in_stb   <= '0;
            op_out_busy <= '1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (claim) begin
                        sel       <= funct3;
                        op_a      <= pico_rs1[31:16];
                        op_b      <= pico_rs1[15:0];
                        op_c      <= pico_rs2[31:16];
                        op_d      <= pico_rs2[15:0];
                        op_in_stb <= req_mask;
                        pico_wait <= 1'b1;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (timeout_hit) begin
                        op_in_stb   <= '0;
                        op_out_busy <= '1;
                        pico_rd     <= 32'hFFFF_FFFF;
                        pico_wr     <= 1'b1;
                        pico_ready  <= 1'b1;
                        pico_wait   <= 1'b0;
                        state       <= StResp;
                    end else if (in_ack) begin
                        op_in_stb   <= op_in_stb & ~sel_mask;
                        op_out_busy <= op_out_busy & ~sel_mask;
                        state       <= StExec;
                    end
                end
                StExec: begin
                    if (timeout_hit) begin
                        op_in_stb   <= '0;
                        op_out_busy <= '1;
                        pico_rd     <= 32'hFFFF_FFFF;
                        pico_wr     <= 1'b1;
                        pico_ready  <= 1'b1;
                        pico_wait   <= 1'b0;
                        state       <= StResp;
                    end else if (out_ack) begin
                        op_out_busy <= '1;
                        pico_rd     <= {16'h0000, sel_result};
                        pico_wr     <= 1'b1;
                        pico_ready  <= 1'b1;
                        pico_wait   <= 1'b0;
                        state       <= StResp;
                    end
                end
                StResp: begin
                    pico_wr    <= 1'b0;
                    pico_ready <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_synq_op_dispatcher.sv
// Directed self-checking bench for synq_op_dispatcher (NUM_OPS=5, TIMEOUT_CYCLES=16).
module tb_synq_op_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        pico_valid;
    logic [31:0] pico_insn;
    logic [31:0] pico_rs1;
    logic [31:0] pico_rs2;
    logic        pico_wr;
    logic [31:0] pico_rd;
    logic        pico_wait;
    logic        pico_ready;
    logic [15:0] op_a, op_b, op_c, op_d;
    logic [4:0]  op_in_stb;
    logic [4:0]  op_in_busy;
    logic [79:0] op_result;
    logic [4:0]  op_out_stb;
    logic [4:0]  op_out_busy;
    logic        timeout_flag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    synq_op_dispatcher #(
        .NUM_OPS        (5),
        .CUSTOM_FUNCT7  (7'b0000001),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pico_valid   (pico_valid),
        .pico_insn    (pico_insn),
        .pico_rs1     (pico_rs1),
        .pico_rs2     (pico_rs2),
        .pico_wr      (pico_wr),
        .pico_rd      (pico_rd),
        .pico_wait    (pico_wait),
        .pico_ready   (pico_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_c         (op_c),
        .op_d         (op_d),
        .op_in_stb    (op_in_stb),
        .op_in_busy   (op_in_busy),
        .op_result    (op_result),
        .op_out_stb   (op_out_stb),
        .op_out_busy  (op_out_busy),
        .timeout_flag (timeout_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Presents one request for a single cycle; the block latches it on that edge.
    task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        pico_valid = 1'b1;
        pico_insn  = mk_insn(f7, f3);
        pico_rs1   = rs1;
        pico_rs2   = rs2;
        tick();
        pico_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({pico_wr, pico_ready, pico_wait} !== 3'b000) begin
            $display("FAIL reset_pico wr/ready/wait=%b expected 000", {pico_wr, pico_ready, pico_wait});
            failures++;
        end
        checks++;
        if ({pico_rd, op_a, op_b, op_c, op_d} !== 96'h0) begin
            $display("FAIL reset_data rd=%h ops=%h %h %h %h expected all 0", pico_rd, op_a, op_b, op_c, op_d);
            failures++;
        end
        checks++;
        if ({op_in_stb, op_out_busy, timeout_flag} !== {5'b00000, 5'b11111, 1'b0}) begin
            $display("FAIL reset_ctrl in_stb=%b out_busy=%b tflag=%b expected 00000 11111 0",
                     op_in_stb, op_out_busy, timeout_flag);
            failures++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        issue(7'b0000001, 3'd0, 32'h0003_0004, 32'h0005_0006);
        checks++;
        if ({op_a, op_b, op_c, op_d} !== {16'd3, 16'd4, 16'd5, 16'd6}) begin
            $display("FAIL basic_operands got %h %h %h %h expected 3 4 5 6", op_a, op_b, op_c, op_d);
            failures++;
        end
        checks++;
        if ({op_in_stb, pico_wait, pico_ready} !== {5'b00001, 1'b1, 1'b0}) begin
            $display("FAIL basic_issue in_stb=%b wait=%b ready=%b expected 00001 1 0",
                     op_in_stb, pico_wait, pico_ready);
            failures++;
        end
        op_in_busy = 5'b00001;
        tick();
        op_in_busy = 5'b00000;
        checks++;
        if ({op_in_stb, op_out_busy, pico_ready} !== {5'b00000, 5'b11110, 1'b0}) begin
            $display("FAIL basic_exec in_stb=%b out_busy=%b ready=%b expected 00000 11110 0",
                     op_in_stb, op_out_busy, pico_ready);
            failures++;
        end
        op_out_stb       = 5'b00001;
        op_result[15:0]  = 16'h1234;
        tick();
        op_out_stb = 5'b00000;
        checks++;
        if ({pico_ready, pico_wr, pico_wait, pico_rd} !== {3'b110, 32'h0000_1234}) begin
            $display("FAIL basic_resp ready/wr/wait=%b rd=%h expected 110 00001234",
                     {pico_ready, pico_wr, pico_wait}, pico_rd);
            failures++;
        end
        checks++;
        if (op_out_busy !== 5'b11111) begin
            $display("FAIL basic_outbusy got %b expected 11111", op_out_busy);
            failures++;
        end
        tick();
        checks++;
        if ({pico_ready, pico_wr, pico_rd} !== {2'b00, 32'h0000_1234}) begin
            $display("FAIL basic_after ready/wr=%b rd=%h expected 00 00001234",
                     {pico_ready, pico_wr}, pico_rd);
            failures++;
        end
    endtask

    task automatic test_slow_unit();
        int bad_stb;
        bad_stb = 0;
        issue(7'b0000001, 3'd4, 32'hAAAA_BBBB, 32'hCCCC_DDDD);
        for (int i = 0; i < 5; i++) begin
            if (op_in_stb !== 5'b10000 || pico_wait !== 1'b1) bad_stb++;
            if (i == 4) op_in_busy = 5'b10000;
            tick();
        end
        op_in_busy = 5'b00000;
        checks++;
        if (bad_stb != 0) begin
            $display("FAIL slow_issue_hold bad cycles=%0d expected 0", bad_stb);
            failures++;
        end
        for (int j = 0; j < 7; j++) begin
            if (op_in_stb !== 5'b00000 || pico_wait !== 1'b1 || pico_ready !== 1'b0) bad_stb++;
            if (j == 6) begin
                op_out_stb        = 5'b10000;
                op_result[79:64]  = 16'hA5A5;
            end
            tick();
        end
        op_out_stb = 5'b00000;
        checks++;
        if (bad_stb != 0) begin
            $display("FAIL slow_exec_wait bad cycles=%0d expected 0", bad_stb);
            failures++;
        end
        checks++;
        if ({pico_ready, pico_rd} !== {1'b1, 32'h0000_A5A5}) begin
            $display("FAIL slow_resp ready=%b rd=%h expected 1 0000a5a5", pico_ready, pico_rd);
            failures++;
        end
        tick();
    endtask

    task automatic test_unclaimed();
        int bad;
        bad = 0;
        pico_valid = 1'b1;
        pico_insn  = mk_insn(7'b0000001, 3'd5);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pico_wait !== 1'b0 || pico_ready !== 1'b0 || op_in_stb !== 5'b00000) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL unclaimed_funct3 bad cycles=%0d expected 0", bad);
            failures++;
        end
        bad = 0;
        pico_insn = mk_insn(7'b0000000, 3'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pico_wait !== 1'b0 || pico_ready !== 1'b0 || op_in_stb !== 5'b00000) bad++;
        end
        pico_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            $display("FAIL unclaimed_funct7 bad cycles=%0d expected 0", bad);
            failures++;
        end
    endtask

    task automatic test_foreign_result();
        issue(7'b0000001, 3'd2, 32'h1, 32'h2);
        op_in_busy = 5'b00100;
        tick();
        op_in_busy = 5'b00000;
        op_out_stb       = 5'b00010;
        op_result[31:16] = 16'h1111;
        tick();
        tick();
        checks++;
        if ({op_out_busy, pico_ready, pico_wait} !== {5'b11011, 1'b0, 1'b1}) begin
            $display("FAIL foreign_ignored out_busy=%b ready=%b wait=%b expected 11011 0 1",
                     op_out_busy, pico_ready, pico_wait);
            failures++;
        end
        op_out_stb       = 5'b00110;
        op_result[47:32] = 16'hBEEF;
        tick();
        op_out_stb = 5'b00000;
        checks++;
        if ({pico_ready, pico_rd} !== {1'b1, 32'h0000_BEEF}) begin
            $display("FAIL foreign_resp ready=%b rd=%h expected 1 0000beef", pico_ready, pico_rd);
            failures++;
        end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        int ready_seen;
        ready_seen = 0;
        issue(7'b0000001, 3'd3, 32'h0009_0008, 32'h0007_0006);
        op_in_busy = 5'b01000;
        tick();
        op_in_busy       = 5'b00000;
        rst              = 1'b1;
        op_out_stb       = 5'b01000;
        op_result[63:48] = 16'h7777;
        tick();
        rst        = 1'b0;
        op_out_stb = 5'b00000;
        checks++;
        if ({pico_wr, pico_ready, pico_wait, pico_rd, op_a, op_in_stb, op_out_busy} !==
            {3'b000, 32'h0, 16'h0, 5'b00000, 5'b11111}) begin
            $display("FAIL midrst_state wr/ready/wait=%b rd=%h op_a=%h in_stb=%b out_busy=%b expected reset",
                     {pico_wr, pico_ready, pico_wait}, pico_rd, op_a, op_in_stb, op_out_busy);
            failures++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pico_ready !== 1'b0) ready_seen++;
        end
        checks++;
        if (ready_seen != 0) begin
            $display("FAIL midrst_noready ready cycles=%0d expected 0", ready_seen);
            failures++;
        end
        issue(7'b0000001, 3'd1, 32'h0, 32'h0);
        op_in_busy = 5'b00010;
        tick();
        op_in_busy       = 5'b00000;
        op_out_stb       = 5'b00010;
        op_result[31:16] = 16'h0F0F;
        tick();
        op_out_stb = 5'b00000;
        checks++;
        if ({pico_ready, pico_wr, pico_rd} !== {2'b11, 32'h0000_0F0F}) begin
            $display("FAIL midrst_next ready/wr=%b rd=%h expected 11 00000f0f",
                     {pico_ready, pico_wr}, pico_rd);
            failures++;
        end
        tick();
    endtask

    task automatic test_timeout();
`ifdef SYNQ_DISPATCH_TIMEOUT_EN
        int edges;
        edges = 1;
        issue(7'b0000001, 3'd0, 32'h0, 32'h0);
        while (pico_ready !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (edges != 17) begin
            $display("FAIL timeout_latency edges=%0d expected 17", edges);
            failures++;
        end
        checks++;
        if ({pico_rd, timeout_flag, op_in_stb, op_out_busy} !==
            {32'hFFFF_FFFF, 1'b1, 5'b00000, 5'b11111}) begin
            $display("FAIL timeout_resp rd=%h tflag=%b in_stb=%b out_busy=%b expected ffffffff 1 00000 11111",
                     pico_rd, timeout_flag, op_in_stb, op_out_busy);
            failures++;
        end
        tick();
        tick();
        checks++;
        if ({timeout_flag, pico_ready} !== 2'b10) begin
            $display("FAIL timeout_sticky tflag/ready=%b expected 10", {timeout_flag, pico_ready});
            failures++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (timeout_flag !== 1'b0) begin
            $display("FAIL timeout_clear tflag=%b expected 0", timeout_flag);
            failures++;
        end
`else
        int bad;
        bad = 0;
        issue(7'b0000001, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (pico_ready !== 1'b0 || pico_wait !== 1'b1 || timeout_flag !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL notimeout_wait bad cycles=%0d expected 0", bad);
            failures++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        pico_valid = 1'b0;
        pico_insn  = '0;
        pico_rs1   = '0;
        pico_rs2   = '0;
        op_in_busy = '0;
        op_result  = '0;
        op_out_stb = '0;
        test_reset();
        test_basic();
        test_slow_unit();
        test_unclaimed();
        test_foreign_result();
        test_reset_mid_exec();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
